multiplier_arbiter: RTL and testbench
=====================================

Name: multiplier_arbiter

Overview:
- Shares one multiplier_32 between two requesters (e.g. ALU and address-generation unit).
- Arbitrates round-robin, latches the winner's operands and drives the multiplier start/enable sequence.
- Waits for the multiplier's done signal with a timeout watchdog, then returns the 64-bit signed product to the winner with a one-cycle done pulse.

Parameters:
- WIDTH, 32: operand width; product width is 2*WIDTH.
- TIMEOUT, 40: maximum BUSY cycles before a request is aborted.
- CNT_W, 6: watchdog counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- req0  in  1  requester 0 request; level, held until done0 or err0.
- a0  in  WIDTH  requester 0 signed multiplicand.
- b0  in  WIDTH  requester 0 signed multiplier.
- req1  in  1  requester 1 request; same protocol as req0.
- a1  in  WIDTH  requester 1 signed multiplicand.
- b1  in  WIDTH  requester 1 signed multiplier.
- done0  out  1  one-cycle pulse; p_out valid for requester 0.
- done1  out  1  one-cycle pulse; p_out valid for requester 1.
- err0  out  1  one-cycle pulse; requester 0 aborted by timeout.
- err1  out  1  one-cycle pulse; requester 1 aborted by timeout.
- p_out  out  2*WIDTH  signed product; holds its last value between operations.
- busy  out  1  high in every state except IDLE.
- mul_a  out  WIDTH  latched operand to multiplier a.
- mul_b  out  WIDTH  latched operand to multiplier b.
- mul_start  out  1  drives the multiplier's active-high start/clear input.
- mul_ena  out  1  multiplier enable.
- mul_p  in  2*WIDTH  multiplier product.
- mul_dne  in  1  multiplier done.

Behaviour:
- Reset (rst=0, asynchronous):
  - State IDLE; priority pointer = 0.
  - All outputs 0, including p_out, mul_a and mul_b.
  - Reset mid-operation abandons the operation; no done or err pulse is issued.
- States:
  - IDLE → START when any req is high.
  - START → BUSY unconditionally.
  - BUSY → DONE when mul_dne=1.
  - BUSY → ABORT when the watchdog reaches TIMEOUT.
  - DONE → IDLE; ABORT → IDLE.
- IDLE:
  - Winner = the only requester asserting req; if both assert, the requester selected by the pointer.
  - On the IDLE→START edge: latch winner id, mul_a <= a_w, mul_b <= b_w; clear the watchdog.
- START: mul_start=1 and mul_ena=1 for exactly one cycle.
- BUSY:
  - mul_ena=1, mul_start=0; watchdog increments each cycle.
  - mul_dne is sampled only from the first BUSY cycle onward, so a stale dne held during START is ignored.
- DONE:
  - p_out <= mul_p is captured on the BUSY→DONE edge.
  - done_w=1 for the single DONE cycle.
  - Pointer <= other requester (the requester just served loses priority).
- ABORT: err_w=1 for one cycle; p_out unchanged; pointer flips as in DONE.
- mul_ena=0 in IDLE, DONE and ABORT.
- Latency:
  - req sampled at IDLE cycle 0 → START cycle 1 → BUSY from cycle 2.
  - done at cycle (first cycle mul_dne=1) + 1.
  - Minimum IDLE gap of one cycle between operations.
- Operand stability: requester inputs may change after grant; mul_a/mul_b stay stable until the next grant.
- req still high in the IDLE cycle after done/err is treated as a new request.
- The non-winning requester waits with its req held; it is never dropped.
- No arithmetic is performed in this block; the product passes through bit-exact.

Decomposition:
- Shared header mul_defs.vh: state encodings (IDLE, START, BUSY, DONE, ABORT, 3 bits) and the WIDTH default.
- One natural sub-module: rr_arbiter_2 (combinational winner select from req0, req1 and the pointer, plus the pointer-flip register).
- The watchdog counter and FSM stay in multiplier_arbiter.
- The bench instantiates multiplier_arbiter with a real multiplier_32 on the mul_* ports.

Test Plan:
- Reset: rst=0 mid-BUSY → all outputs 0 immediately; after release, req1 alone (a1=5, b1=6) → done1 with p_out=30, no stale done or err.
- Single: req0, a0=7, b0=-3 → one done0 pulse, p_out=-21; done1, err0 and err1 stay 0.
- Contention from reset: req0=req1=1 (a0=3,b0=4; a1=-2147483648, b1=-2147483648) → done0 (p=12) first, then done1 (p=4611686018427387904); both again → requester 0 first.
- Operand hold: change a0 to 99 during BUSY → mul_a unchanged; done0 carries the product of the latched operands.
- Timeout: stub mul_dne stuck at 0 → err0 pulse after TIMEOUT BUSY cycles, no done0, p_out unchanged; pending req1 is served next.
- Stale dne: mul_dne held 1 through START → done is not issued until mul_dne is sampled in BUSY.

Source files
------------

// File: rtl/multiplier_arbiter_pkg.sv
// multiplier_arbiter_pkg: state encoding and width default shared by the multiplier arbiter slice
package multiplier_arbiter_pkg;
  localparam int WIDTH_DEF = 32;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    BUSY  = 3'd2,
    DONE  = 3'd3,
    ABORT = 3'd4
  } state_t;
endpackage

// File: rtl/multiplier_32.sv
// multiplier_32: fixed-latency signed 32x32 multiplier; start clears and loads, done holds until the next start
module multiplier_32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        ena,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] p,
  output logic        dne
);
  localparam logic [1:0] LAT = 2'd3;
  logic signed [31:0] ra, rb;
  logic [1:0] cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt <= '0;
      dne <= 1'b0;
      p   <= '0;
      ra  <= '0;
      rb  <= '0;
    end else if (start) begin
      cnt <= LAT;
      dne <= 1'b0;
      ra  <= a;
      rb  <= b;
    end else if (ena && cnt != 2'd0) begin
      cnt <= cnt - 2'd1;
      if (cnt == 2'd1) begin
        p   <= 64'(ra) * 64'(rb);
        dne <= 1'b1;
      end
    end
endmodule

// File: rtl/multiplier_arbiter_rr.sv
// rr_arbiter_2: two-way round-robin winner select with a pointer that moves away from the last served requester
module rr_arbiter_2 (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic flip,
  input  logic served,
  output logic win
);
  logic ptr;
  assign win = (req0 && req1) ? ptr : req1;
  always_ff @(posedge clk or negedge rst)
    if (!rst) ptr <= 1'b0;
    else if (flip) ptr <= ~served;
endmodule

// File: rtl/multiplier_arbiter.sv
// multiplier_arbiter: shares one multiplier between two requesters with round-robin grant and a timeout watchdog
module multiplier_arbiter
  import multiplier_arbiter_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int TIMEOUT = 40,
  parameter int CNT_W   = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0,
  input  logic [WIDTH-1:0]   a0,
  input  logic [WIDTH-1:0]   b0,
  input  logic               req1,
  input  logic [WIDTH-1:0]   a1,
  input  logic [WIDTH-1:0]   b1,
  output logic               done0,
  output logic               done1,
  output logic               err0,
  output logic               err1,
  output logic [2*WIDTH-1:0] p_out,
  output logic               busy,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  output logic               mul_start,
  output logic               mul_ena,
  input  logic [2*WIDTH-1:0] mul_p,
  input  logic               mul_dne
);
  state_t state, nxt;
  logic id, win;
  logic [CNT_W-1:0] cnt;
  rr_arbiter_2 u_rr (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .flip(state == DONE || state == ABORT), .served(id), .win(win)
  );
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:    nxt = (req0 || req1) ? START : IDLE;
      START:   nxt = BUSY;
      BUSY:    nxt = mul_dne ? DONE : (cnt == CNT_W'(TIMEOUT - 1)) ? ABORT : BUSY;
      default: nxt = IDLE;
    endcase
  end
  assign busy      = state != IDLE;
  assign mul_start = state == START;
  assign mul_ena   = state == START || state == BUSY;
  assign done0     = state == DONE && !id;
  assign done1     = state == DONE && id;
  assign err0      = state == ABORT && !id;
  assign err1      = state == ABORT && id;
  // dne only matters in BUSY, so a value left over from the previous product is never taken
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      id    <= 1'b0;
      cnt   <= '0;
      mul_a <= '0;
      mul_b <= '0;
      p_out <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && nxt == START) begin
        id    <= win;
        mul_a <= win ? a1 : a0;
        mul_b <= win ? b1 : b0;
        cnt   <= '0;
      end
      if (state == BUSY) cnt <= cnt + 1'b1;
      if (state == BUSY && nxt == DONE) p_out <= mul_p;
    end
endmodule

// File: tb/tb_multiplier_arbiter.sv
// tb_multiplier_arbiter: directed scoreboard bench for multiplier_arbiter driving a real multiplier_32
module tb_multiplier_arbiter;
  localparam int TIMEOUT = 40;
  localparam logic [3:0] D0 = 4'b1000, D1 = 4'b0100, E0 = 4'b0010;
  typedef struct packed {logic [3:0] pv; logic [63:0] p;} exp_t;
  logic clk, rst, req0, req1, done0, done1, err0, err1, busy, mul_start, mul_ena, mul_dne, m_dne;
  logic [31:0] a0, b0, a1, b1, mul_a, mul_b;
  logic [63:0] p_out, mul_p;
  logic [1:0] mode;
  logic [134:0] outs;
  exp_t sb[$];
  int n_checks = 0, n_fail = 0;

  multiplier_arbiter #(.WIDTH(32), .TIMEOUT(TIMEOUT), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .req0(req0), .a0(a0), .b0(b0), .req1(req1), .a1(a1), .b1(b1),
    .done0(done0), .done1(done1), .err0(err0), .err1(err1), .p_out(p_out), .busy(busy),
    .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start), .mul_ena(mul_ena),
    .mul_p(mul_p), .mul_dne(mul_dne)
  );
  multiplier_32 u_mul (
    .clk(clk), .rst(rst), .start(mul_start), .ena(mul_ena), .a(mul_a), .b(mul_b),
    .p(mul_p), .dne(m_dne)
  );
  // mode 1 models a hung multiplier, mode 2 a done line stuck high
  assign mul_dne = mode == 2'd0 ? m_dne : mode == 2'd2;
  assign outs = {done0, done1, err0, err1, busy, mul_start, mul_ena, p_out, mul_a, mul_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] pv, input logic [63:0] p);
    sb.push_back('{pv, p});
  endtask

  task automatic wait_evt(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(done0 || done1 || err0 || err1) && cyc < 200);
    chk("event_seen", 160'(done0 || done1 || err0 || err1), 160'(1));
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (done0 || done1 || err0 || err1) begin
      if (sb.size() == 0) chk("unexpected_pulse", 160'({done0, done1, err0, err1}), 160'(0));
      else begin
        e = sb.pop_front();
        chk("pulse_id", 160'({done0, done1, err0, err1}), 160'(e.pv));
        chk("p_out", 160'(p_out), 160'(e.p));
      end
    end
  end

  initial begin
    int cyc;
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0; mode = 2'd0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 160'(outs), 160'(0));
    rst = 1'b1;
    @(negedge clk);
    a0 = 32'd3; b0 = 32'd4; a1 = 32'h8000_0000; b1 = 32'h8000_0000; req0 = 1'b1; req1 = 1'b1;
    push(D0, 64'd12);
    push(D1, 64'h4000_0000_0000_0000);
    wait_evt(cyc);
    chk("contend_first_lat", 160'(cyc), 160'(6));
    req0 = 1'b0;
    wait_evt(cyc);
    chk("contend_second_lat", 160'(cyc), 160'(7));
    req1 = 1'b0;
    @(negedge clk);
    chk("pulse_one_cycle", 160'({done0, done1, busy}), 160'(0));
    a0 = -32'sd5; b0 = 32'd9; a1 = 32'd100000; b1 = 32'd300000; req0 = 1'b1; req1 = 1'b1;
    push(D0, -64'sd45);
    push(D1, 64'd30000000000);
    wait_evt(cyc);
    chk("again_first_lat", 160'(cyc), 160'(6));
    req0 = 1'b0;
    wait_evt(cyc);
    chk("again_second_lat", 160'(cyc), 160'(7));
    req1 = 1'b0;
    @(negedge clk);
    a0 = 32'd7; b0 = -32'sd3; req0 = 1'b1;
    push(D0, -64'sd21);
    wait_evt(cyc);
    chk("single_lat", 160'(cyc), 160'(6));
    req0 = 1'b0;
    @(negedge clk);
    a0 = 32'd11; b0 = 32'd13; req0 = 1'b1;
    push(D0, 64'd143);
    repeat (3) @(negedge clk);
    a0 = 32'd99; b0 = 32'd1;
    @(negedge clk);
    chk("hold_mul_a", 160'(mul_a), 160'(11));
    chk("hold_mul_b", 160'(mul_b), 160'(13));
    wait_evt(cyc);
    chk("hold_lat", 160'(cyc), 160'(2));
    req0 = 1'b0;
    @(negedge clk);
    mode = 2'd1; a0 = 32'd2; b0 = 32'd2; req0 = 1'b1;
    push(E0, 64'd143);
    @(negedge clk);
    a1 = 32'd6; b1 = 32'd7; req1 = 1'b1;
    push(D1, 64'd42);
    wait_evt(cyc);
    chk("timeout_lat", 160'(cyc), 160'(TIMEOUT + 1));
    mode = 2'd0; req0 = 1'b0;
    wait_evt(cyc);
    chk("after_abort_lat", 160'(cyc), 160'(7));
    req1 = 1'b0;
    @(negedge clk);
    mode = 2'd2; a1 = -32'sd8; b1 = 32'd8; req1 = 1'b1;
    push(D1, -64'sd64);
    @(negedge clk);
    chk("stale_dne_start", 160'({mul_start, done1, busy}), 160'(3'b101));
    mode = 2'd0;
    wait_evt(cyc);
    chk("stale_dne_lat", 160'(cyc), 160'(5));
    req1 = 1'b0;
    @(negedge clk);
    a0 = 32'd1; b0 = 32'd1; req0 = 1'b1;
    repeat (3) @(negedge clk);
    chk("busy_before_reset", 160'({busy, mul_ena}), 160'(2'b11));
    rst = 1'b0; req0 = 1'b0;
    #1;
    chk("async_reset_outputs", 160'(outs), 160'(0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    a1 = 32'd5; b1 = 32'd6; req1 = 1'b1;
    push(D1, 64'd30);
    wait_evt(cyc);
    chk("post_reset_lat", 160'(cyc), 160'(6));
    req1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 160'(sb.size()), 160'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
